// File: rtl/usb_xfer_engine_if.sv
// rtl/usb_xfer_engine_if.sv - host stream, response and memory-port bundle for usb_xfer_engine
interface usb_xfer_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [31:0]       cmd_tdata;
  logic              cmd_tvalid;
  logic              cmd_tready;
  logic [31:0]       resp_tdata;
  logic              resp_tvalid;
  logic              resp_tlast;
  logic              resp_tready;
  logic [DATA_W-1:0] dtx_tdata;
  logic              dtx_tvalid;
  logic              dtx_tready;
  logic [DATA_W-1:0] drx_tdata;
  logic              drx_tvalid;
  logic              drx_tlast;
  logic              drx_tready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wr_data;
  logic              mem_wr_ready;
  logic              mem_rd;
  logic              mem_rd_ready;
  logic              mem_rd_valid;
  logic [DATA_W-1:0] mem_rd_data;

  modport master (
    input  cmd_tdata, cmd_tvalid, resp_tready, dtx_tdata, dtx_tvalid, drx_tready,
    input  mem_wr_ready, mem_rd_ready, mem_rd_valid, mem_rd_data,
    output cmd_tready, resp_tdata, resp_tvalid, resp_tlast, dtx_tready,
    output drx_tdata, drx_tvalid, drx_tlast, mem_addr, mem_wr, mem_wr_data, mem_rd
  );

  modport slave (
    output cmd_tdata, cmd_tvalid, resp_tready, dtx_tdata, dtx_tvalid, drx_tready,
    output mem_wr_ready, mem_rd_ready, mem_rd_valid, mem_rd_data,
    input  cmd_tready, resp_tdata, resp_tvalid, resp_tlast, dtx_tready,
    input  drx_tdata, drx_tvalid, drx_tlast, mem_addr, mem_wr, mem_wr_data, mem_rd
  );
endinterface

// File: rtl/usb_xfer_engine.sv
// rtl/usb_xfer_engine.sv - FX3 host command decoder and OUT/IN burst engine with read prefetch
// Optional stall abort enabled by defining USB_XFER_TIMEOUT_EN.
module usb_xfer_engine #(
  parameter int                DATA_W       = 32,
  parameter int                ADDR_W       = 32,
  parameter logic [ADDR_W:0]   ADDR_SPACE   = 'h2000_0000,
  parameter int                RD_BUF_DEPTH = 8,
  parameter logic [63:0]       FINGERPRINT  = 64'h47424120492F4F0A,
  parameter int                TIMEOUT_CYC  = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  usb_xfer_engine_if.master  bus,
  output logic               soft_rst,
  output logic               busy
);
  localparam int          BEAT_B  = DATA_W / 8;
  localparam int          AL      = $clog2(BEAT_B);
  localparam int          PW      = $clog2(RD_BUF_DEPTH);
  localparam logic [31:0] BEAT_SZ = 32'(BEAT_B);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_CMD2, S_CHECK, S_WRITE, S_READ, S_RESP0, S_RESP1
  } state_t;

  state_t            state_q;
  logic [7:0]        opcode_q;
  logic [7:0]        status_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       size_q;
  logic [31:0]       off_q;
  logic [31:0]       pop_off_q;
  logic [31:0]       bytes_q;
  logic [PW:0]       fifo_cnt_q;
  logic [PW:0]       outst_q;
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [DATA_W-1:0] fifo_q [RD_BUF_DEPTH];

  logic              cmd_hs, wr_hs, rd_req_hs, push, pop, resp_hs, range_ok, rd_ret;
  logic [31:0]       last_off;
  logic [ADDR_W:0]   end_addr;

`ifdef USB_XFER_TIMEOUT_EN
  localparam int     TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0]     stall_q;
  logic              drain_q;
  logic              any_hs;
  assign any_hs = wr_hs || pop || rd_req_hs || bus.mem_rd_valid;
`else
  logic              drain_q;
  logic              unused_timeout;
  assign drain_q        = 1'b0;
  assign unused_timeout = (TIMEOUT_CYC == 0);
`endif

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  assign last_off  = size_q - BEAT_SZ;
  assign end_addr  = {1'b0, addr_q} + (ADDR_W+1)'(size_q);
  assign range_ok  = (size_q != 32'd0) && (size_q[AL-1:0] == '0) &&
                     (addr_q[AL-1:0] == '0) && (end_addr <= ADDR_SPACE);

  assign cmd_hs    = bus.cmd_tvalid && bus.cmd_tready;
  assign wr_hs     = (state_q == S_WRITE) && bus.dtx_tvalid && bus.mem_wr_ready;
  assign rd_req_hs = bus.mem_rd && bus.mem_rd_ready;
  assign rd_ret    = bus.mem_rd_valid && (outst_q != '0);
  // Returns that arrive while draining an aborted read are dropped, never buffered.
  assign push      = rd_ret && (state_q == S_READ) && !drain_q;
  assign pop       = bus.drx_tvalid && bus.drx_tready;
  assign resp_hs   = bus.resp_tvalid && bus.resp_tready;

  assign bus.cmd_tready  = (state_q == S_IDLE) || (state_q == S_CMD1) || (state_q == S_CMD2);
  assign bus.resp_tvalid = (state_q == S_RESP0) || (state_q == S_RESP1);
  assign bus.resp_tlast  = (state_q == S_RESP1);
  assign bus.resp_tdata  = (state_q == S_RESP0)
                         ? ((opcode_q == 8'h01) ? bswap(FINGERPRINT[63:32]) : {16'h0, status_q, opcode_q})
                         : ((opcode_q == 8'h01) ? bswap(FINGERPRINT[31:0])  : bytes_q);

  assign bus.mem_addr    = addr_q + off_q[ADDR_W-1:0];
  assign bus.mem_wr      = (state_q == S_WRITE) && bus.dtx_tvalid;
  assign bus.mem_wr_data = bus.dtx_tdata;
  assign bus.dtx_tready  = (state_q == S_WRITE) && bus.mem_wr_ready;
  // Credit check counts in-flight reads so the prefetch FIFO can never overflow.
  assign bus.mem_rd      = (state_q == S_READ) && !drain_q && (off_q < size_q) &&
                           (({1'b0, outst_q} + {1'b0, fifo_cnt_q}) < (PW+2)'(RD_BUF_DEPTH));
  assign bus.drx_tvalid  = (state_q == S_READ) && (fifo_cnt_q != '0);
  assign bus.drx_tdata   = fifo_q[rd_ptr_q];
  assign bus.drx_tlast   = bus.drx_tvalid && (pop_off_q == last_off);

  assign soft_rst = (state_q == S_CHECK) && (opcode_q == 8'hFF);
  assign busy     = (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= bus.mem_rd_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opcode_q   <= '0;
      status_q   <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      off_q      <= '0;
      pop_off_q  <= '0;
      bytes_q    <= '0;
      fifo_cnt_q <= '0;
      outst_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
`ifdef USB_XFER_TIMEOUT_EN
      stall_q    <= '0;
      drain_q    <= 1'b0;
`endif
    end else begin
      if (rd_req_hs && !rd_ret)      outst_q <= outst_q + 1'b1;
      else if (!rd_req_hs && rd_ret) outst_q <= outst_q - 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
      else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;

      case (state_q)
        S_IDLE: if (cmd_hs) begin
          opcode_q <= bus.cmd_tdata[7:0];
          state_q  <= S_CMD1;
        end
        S_CMD1: if (cmd_hs) begin
          addr_q  <= bus.cmd_tdata[ADDR_W-1:0];
          state_q <= S_CMD2;
        end
        S_CMD2: if (cmd_hs) begin
          size_q    <= bus.cmd_tdata;
          off_q     <= '0;
          pop_off_q <= '0;
          bytes_q   <= '0;
          status_q  <= 8'h00;
          state_q   <= S_CHECK;
        end
        S_CHECK: begin
          case (opcode_q)
            8'h40, 8'h80: begin
              if (range_ok) state_q <= (opcode_q == 8'h40) ? S_READ : S_WRITE;
              else begin
                status_q <= 8'h02;
                state_q  <= S_RESP0;
              end
            end
            8'h01, 8'hFF: state_q <= S_RESP0;
            default: begin
              status_q <= 8'h01;
              state_q  <= S_RESP0;
            end
          endcase
        end
        S_WRITE: if (wr_hs) begin
          off_q   <= off_q + BEAT_SZ;
          bytes_q <= bytes_q + BEAT_SZ;
          if (off_q == last_off) state_q <= S_RESP0;
        end
        S_READ: begin
          if (rd_req_hs) off_q <= off_q + BEAT_SZ;
          if (pop) begin
            pop_off_q <= pop_off_q + BEAT_SZ;
            bytes_q   <= bytes_q + BEAT_SZ;
            if (pop_off_q == last_off) state_q <= S_RESP0;
          end
        end
        S_RESP0: if (resp_hs) state_q <= S_RESP1;
        S_RESP1: if (resp_hs) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase

`ifdef USB_XFER_TIMEOUT_EN
      if (drain_q && (outst_q == '0)) drain_q <= 1'b0;
      if ((state_q == S_WRITE) || (state_q == S_READ)) begin
        if (any_hs) stall_q <= '0;
        else if (stall_q == TW'(TIMEOUT_CYC - 1)) begin
          // No handshake this cycle, so nothing is pushed or popped while flushing.
          state_q    <= S_RESP0;
          status_q   <= 8'h03;
          stall_q    <= '0;
          fifo_cnt_q <= '0;
          wr_ptr_q   <= '0;
          rd_ptr_q   <= '0;
          drain_q    <= (outst_q != '0);
        end else stall_q <= stall_q + 1'b1;
      end else stall_q <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_usb_xfer_engine.sv
// tb/tb_usb_xfer_engine.sv - randomized self-checking bench for usb_xfer_engine
`timescale 1ns/1ps
module tb_usb_xfer_engine;
  localparam int     DATA_W = 32;
  localparam int     ADDR_W = 32;
  localparam int     DEPTH  = 8;
  localparam longint ASPACE = 64'h2000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic soft_rst, busy;
  always #5 clk = ~clk;

  usb_xfer_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  usb_xfer_engine #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .ADDR_SPACE(33'h2000_0000),
    .RD_BUF_DEPTH(DEPTH), .FINGERPRINT(64'h47424120492F4F0A), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if), .soft_rst(soft_rst), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct { logic [31:0] data; int cnt; } rd_t;
  rd_t         rd_pipe[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] wr_addr_log[$], wr_data_log[$];
  logic [31:0] rx_data[$];
  logic        rx_last[$];
  int rd_issued = 0, drx_popped = 0, max_occ = 0, rd_seen = 0, soft_cnt = 0;
  int rd_lat = 3;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], ~a[15:0]} ^ 32'h5A3C_0000;
  endfunction

  // Memory responder: in-order reads with fixed latency, random ready.
  initial begin
    bus_if.mem_wr_ready = 1'b0;
    bus_if.mem_rd_ready = 1'b0;
    bus_if.mem_rd_valid = 1'b0;
    bus_if.mem_rd_data  = '0;
    forever begin
      @(negedge clk);
      if (rd_issued - drx_popped > max_occ) max_occ = rd_issued - drx_popped;
      foreach (rd_pipe[i]) rd_pipe[i].cnt = rd_pipe[i].cnt - 1;
      if (rd_pipe.size() != 0 && rd_pipe[0].cnt <= 0) begin
        bus_if.mem_rd_valid = 1'b1;
        bus_if.mem_rd_data  = rd_pipe[0].data;
        void'(rd_pipe.pop_front());
      end else begin
        bus_if.mem_rd_valid = 1'b0;
      end
      bus_if.mem_wr_ready = ($urandom_range(3) != 0);
      bus_if.mem_rd_ready = ($urandom_range(3) != 0);
      #1;
      if (rst) rd_pipe.delete();
      else begin
        if (soft_rst) soft_cnt++;
        if (bus_if.mem_rd) rd_seen++;
        if (bus_if.mem_rd && bus_if.mem_rd_ready) begin
          rd_pipe.push_back('{rd_word(bus_if.mem_addr), rd_lat});
          rd_issued++;
        end
        if (bus_if.mem_wr && bus_if.mem_wr_ready) begin
          mem_m[bus_if.mem_addr] = bus_if.mem_wr_data;
          wr_addr_log.push_back(bus_if.mem_addr);
          wr_data_log.push_back(bus_if.mem_wr_data);
        end
      end
    end
  end

  task automatic send_cmd(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [31:0] w [3];
    int guard;
    bit ok;
    w[0] = w0; w[1] = w1; w[2] = w2;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      guard = 0;
      @(negedge clk);
      bus_if.cmd_tdata  = w[i];
      bus_if.cmd_tvalid = 1'b1;
      #1;
      while (!bus_if.cmd_tready && guard < 200) begin
        @(negedge clk); #1; guard++;
      end
      if (guard >= 200) ok = 1'b0;
    end
    @(negedge clk);
    bus_if.cmd_tvalid = 1'b0;
    n_checks++;
    if (ok !== 1'b1) $display("FAIL cmd_accept: accepted=%0d expected=1", ok); else n_pass++;
  endtask

  task automatic send_dtx(input logic [31:0] words[$], input bit gaps);
    int idx = 0, guard = 0;
    while (idx < words.size() && guard < 5000) begin
      @(negedge clk); guard++;
      if (gaps && $urandom_range(2) == 0) bus_if.dtx_tvalid = 1'b0;
      else begin
        bus_if.dtx_tvalid = 1'b1;
        bus_if.dtx_tdata  = words[idx];
      end
      #1;
      if (bus_if.dtx_tvalid && bus_if.dtx_tready) idx++;
    end
    @(negedge clk);
    bus_if.dtx_tvalid = 1'b0;
    n_checks++;
    if (idx != words.size()) $display("FAIL dtx_sent: beats=%0d expected=%0d", idx, words.size());
    else n_pass++;
  endtask

  task automatic recv_drx(input int n, input bit rand_mode);
    int guard = 0;
    rx_data.delete(); rx_last.delete();
    while (rx_data.size() < n && guard < 5000) begin
      @(negedge clk); guard++;
      bus_if.drx_tready = rand_mode ? ($urandom_range(2) == 0) : guard[0];
      #1;
      if (bus_if.drx_tvalid && bus_if.drx_tready) begin
        rx_data.push_back(bus_if.drx_tdata);
        rx_last.push_back(bus_if.drx_tlast);
        drx_popped++;
      end
    end
    @(negedge clk);
    bus_if.drx_tready = 1'b0;
    n_checks++;
    if (rx_data.size() != n) $display("FAIL drx_count: beats=%0d expected=%0d", rx_data.size(), n);
    else n_pass++;
  endtask

  task automatic get_resp(output logic [31:0] r0, output logic [31:0] r1, output logic l0, output logic l1);
    int got = 0, guard = 0;
    r0 = 'x; r1 = 'x; l0 = 'x; l1 = 'x;
    while (got < 2 && guard < 5000) begin
      @(negedge clk); guard++;
      bus_if.resp_tready = ($urandom_range(1) == 0);
      #1;
      if (bus_if.resp_tvalid && bus_if.resp_tready) begin
        if (got == 0) begin r0 = bus_if.resp_tdata; l0 = bus_if.resp_tlast; end
        else          begin r1 = bus_if.resp_tdata; l1 = bus_if.resp_tlast; end
        got++;
      end
    end
    @(negedge clk);
    bus_if.resp_tready = 1'b0;
    n_checks++;
    if (got != 2) $display("FAIL resp_count: words=%0d expected=2", got); else n_pass++;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (bus_if.resp_tvalid !== 1'b0) $display("FAIL rst_resp_tvalid: got=%b exp=0", bus_if.resp_tvalid); else n_pass++;
    n_checks++; if (bus_if.drx_tvalid !== 1'b0) $display("FAIL rst_drx_tvalid: got=%b exp=0", bus_if.drx_tvalid); else n_pass++;
    n_checks++; if (bus_if.mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got=%b exp=0", bus_if.mem_rd); else n_pass++;
    n_checks++; if (bus_if.mem_wr !== 1'b0) $display("FAIL rst_mem_wr: got=%b exp=0", bus_if.mem_wr); else n_pass++;
    n_checks++; if (soft_rst !== 1'b0) $display("FAIL rst_soft_rst: got=%b exp=0", soft_rst); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got=%b exp=0", busy); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++; if (bus_if.cmd_tready !== 1'b1) $display("FAIL idle_cmd_tready: got=%b exp=1", bus_if.cmd_tready); else n_pass++;
  endtask

  task automatic test_write();
    logic [31:0] words[$];
    logic [31:0] r0, r1;
    logic l0, l1;
    int errs = 0;
    wr_addr_log.delete(); wr_data_log.delete();
    for (int i = 0; i < 4; i++) words.push_back(32'h10 + i);
    send_cmd(32'h80, 32'h100, 32'd16);
    fork
      send_dtx(words, 1'b1);
      get_resp(r0, r1, l0, l1);
    join
    n_checks++; if (wr_addr_log.size() != 4) $display("FAIL wr_count: got=%0d exp=4", wr_addr_log.size()); else n_pass++;
    for (int i = 0; i < wr_addr_log.size() && i < 4; i++)
      if (wr_addr_log[i] !== 32'h100 + 4*i || wr_data_log[i] !== 32'h10 + i) errs++;
    n_checks++; if (errs != 0) $display("FAIL wr_beats: bad_beats=%0d exp=0", errs); else n_pass++;
    n_checks++; if (r0 !== 32'h0000_0080) $display("FAIL wr_resp0: got=%h exp=00000080", r0); else n_pass++;
    n_checks++; if (r1 !== 32'h10 || l1 !== 1'b1 || l0 !== 1'b0) $display("FAIL wr_resp1: got=%h last=%b%b exp=00000010 last=01", r1, l0, l1); else n_pass++;
  endtask

  task automatic test_read();
    logic [31:0] exp[$];
    logic [31:0] r0, r1;
    logic l0, l1;
    int errs = 0;
    for (int i = 0; i < 4; i++) exp.push_back(rd_word(32'h100 + 4*i));
    rd_lat = 3; rd_issued = 0; drx_popped = 0; max_occ = 0;
    send_cmd(32'h40, 32'h100, 32'd16);
    fork
      recv_drx(4, 1'b0);
      get_resp(r0, r1, l0, l1);
    join
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== exp[i] || rx_last[i] !== (i == 3)) errs++;
    n_checks++; if (errs != 0) $display("FAIL rd_beats: bad_beats=%0d exp=0", errs); else n_pass++;
    n_checks++; if (r0 !== 32'h0000_0040 || r1 !== 32'h10) $display("FAIL rd_resp: got=%h,%h exp=00000040,00000010", r0, r1); else n_pass++;
    n_checks++; if (max_occ > DEPTH) $display("FAIL rd_occupancy: got=%0d max=%0d", max_occ, DEPTH); else n_pass++;
  endtask

  task automatic test_range_error();
    logic [31:0] r0, r1;
    logic l0, l1;
    int errs = 0;
    rd_seen = 0;
    send_cmd(32'h40, 32'h1FFF_FFF8, 32'd16);
    get_resp(r0, r1, l0, l1);
    n_checks++; if (rd_seen != 0) $display("FAIL range_no_rd: got=%0d exp=0", rd_seen); else n_pass++;
    n_checks++; if (r0 !== 32'h0000_0240 || r1 !== 32'h0) $display("FAIL range_resp: got=%h,%h exp=00000240,00000000", r0, r1); else n_pass++;
    send_cmd(32'h80, 32'h100, 32'd6);
    get_resp(r0, r1, l0, l1);
    n_checks++; if (r0 !== 32'h0000_0280 || r1 !== 32'h0) $display("FAIL unaligned_resp: got=%h,%h exp=00000280,00000000", r0, r1); else n_pass++;
    // The last four legal words end exactly at the address-space bound.
    send_cmd(32'h40, 32'h1FFF_FFF0, 32'd16);
    fork
      recv_drx(4, 1'b1);
      get_resp(r0, r1, l0, l1);
    join
    for (int i = 0; i < rx_data.size(); i++)
      if (rx_data[i] !== rd_word(32'h1FFF_FFF0 + 4*i)) errs++;
    n_checks++; if (errs != 0 || r0 !== 32'h40 || r1 !== 32'h10) $display("FAIL top_read: bad=%0d resp=%h,%h exp=0,00000040,00000010", errs, r0, r1); else n_pass++;
  endtask

  task automatic test_ident_reset();
    string s = "GBA I/O\n";
    logic [31:0] e0, e1, r0, r1;
    logic l0, l1;
    e0 = {s[3], s[2], s[1], s[0]};
    e1 = {s[7], s[6], s[5], s[4]};
    send_cmd(32'hFFFF_FF01, 32'h0, 32'h0);
    get_resp(r0, r1, l0, l1);
    n_checks++; if (r0 !== e0 || r1 !== e1 || l1 !== 1'b1) $display("FAIL ident: got=%h,%h last=%b exp=%h,%h last=1", r0, r1, l1, e0, e1); else n_pass++;
    soft_cnt = 0;
    send_cmd(32'hFF, 32'h0, 32'h0);
    get_resp(r0, r1, l0, l1);
    n_checks++; if (soft_cnt != 1) $display("FAIL soft_rst_pulse: cycles=%0d exp=1", soft_cnt); else n_pass++;
    n_checks++; if (r0 !== 32'h0000_00FF || r1 !== 32'h0) $display("FAIL reset_resp: got=%h,%h exp=000000ff,00000000", r0, r1); else n_pass++;
    send_cmd(32'h33, 32'h0, 32'h0);
    get_resp(r0, r1, l0, l1);
    n_checks++; if (r0 !== 32'h0000_0133) $display("FAIL unknown_op: got=%h exp=00000133", r0); else n_pass++;
  endtask

  task automatic test_mid_reset();
    logic [31:0] words[$];
    logic [31:0] r0, r1;
    logic l0, l1;
    send_cmd(32'h40, 32'h300, 32'd64);
    repeat (12) @(negedge clk);
    #1;
    n_checks++; if (bus_if.drx_tvalid !== 1'b1) $display("FAIL mid_prefetch: drx_tvalid=%b exp=1", bus_if.drx_tvalid); else n_pass++;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if ({bus_if.drx_tvalid, bus_if.resp_tvalid, bus_if.mem_rd, busy} !== 4'b0000)
      $display("FAIL mid_rst_outputs: drx/resp/mem_rd/busy=%b exp=0000", {bus_if.drx_tvalid, bus_if.resp_tvalid, bus_if.mem_rd, busy});
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wr_addr_log.delete(); wr_data_log.delete();
    for (int i = 0; i < 3; i++) words.push_back($urandom);
    send_cmd(32'h80, 32'h500, 32'd12);
    fork
      send_dtx(words, 1'b0);
      get_resp(r0, r1, l0, l1);
    join
    n_checks++; if (r0 !== 32'h80 || r1 !== 32'd12 || wr_data_log.size() != 3) $display("FAIL post_rst_write: resp=%h,%h writes=%0d exp=00000080,0000000c,3", r0, r1, wr_data_log.size()); else n_pass++;
  endtask

  task automatic test_random();
    for (int it = 0; it < 14; it++) begin
      logic [7:0]  op;
      logic [31:0] addr, size, r0, r1, exp_r0, exp_r1;
      logic [31:0] words[$], exp[$];
      logic        l0, l1, legal, rw;
      int          sel, errs, nb;
      sel = $urandom_range(9);
      op  = (sel < 4) ? 8'h40 : (sel < 8) ? 8'h80 : 8'($urandom_range(2, 63));
      case ($urandom_range(3))
        0:       addr = 32'h2000_0000 - 32'(4 * $urandom_range(0, 16));
        1:       addr = 32'($urandom_range(0, 1023));
        default: addr = 32'h400 + 32'(4 * $urandom_range(0, 255));
      endcase
      size  = ($urandom_range(3) == 0) ? 32'($urandom_range(0, 70)) : 32'(4 * $urandom_range(1, 20));
      rw    = (op == 8'h40) || (op == 8'h80);
      legal = (size != 0) && (size % 4 == 0) && (addr % 4 == 0) && (longint'(addr) + longint'(size) <= ASPACE);
      exp_r0 = {16'h0, (rw ? (legal ? 8'h00 : 8'h02) : 8'h01), op};
      exp_r1 = (rw && legal) ? size : 32'h0;
      nb     = int'(size / 4);
      errs   = 0;
      wr_addr_log.delete(); wr_data_log.delete();
      rd_issued = 0; drx_popped = 0; max_occ = 0;
      rd_lat = $urandom_range(1, 6);
      send_cmd({24'($urandom), op}, addr, size);
      if (rw && legal && op == 8'h80) begin
        for (int i = 0; i < nb; i++) words.push_back($urandom);
        fork
          send_dtx(words, 1'b1);
          get_resp(r0, r1, l0, l1);
        join
        if (wr_addr_log.size() != nb) errs++;
        for (int i = 0; i < wr_addr_log.size() && i < nb; i++)
          if (wr_addr_log[i] !== addr + 32'(4*i) || wr_data_log[i] !== words[i]) errs++;
      end else if (rw && legal) begin
        for (int i = 0; i < nb; i++) exp.push_back(rd_word(addr + 32'(4*i)));
        fork
          recv_drx(nb, 1'b1);
          get_resp(r0, r1, l0, l1);
        join
        for (int i = 0; i < rx_data.size(); i++)
          if (rx_data[i] !== exp[i] || rx_last[i] !== (i == nb - 1)) errs++;
        if (max_occ > DEPTH) errs++;
      end else begin
        get_resp(r0, r1, l0, l1);
      end
      n_checks++; if (r0 !== exp_r0 || r1 !== exp_r1) $display("FAIL rand_resp[%0d]: got=%h,%h exp=%h,%h", it, r0, r1, exp_r0, exp_r1); else n_pass++;
      n_checks++; if (errs != 0) $display("FAIL rand_payload[%0d]: bad=%0d exp=0", it, errs); else n_pass++;
    end
  endtask

`ifdef USB_XFER_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] words[$];
    logic [31:0] r0, r1;
    logic l0, l1;
    words.push_back(32'hAA); words.push_back(32'hBB);
    send_cmd(32'h80, 32'h200, 32'd16);
    send_dtx(words, 1'b0);
    get_resp(r0, r1, l0, l1);
    n_checks++; if (r0 !== 32'h0000_0380 || r1 !== 32'd8) $display("FAIL timeout_resp: got=%h,%h exp=00000380,00000008", r0, r1); else n_pass++;
  endtask
`endif

  initial begin
    bus_if.cmd_tdata   = '0;
    bus_if.cmd_tvalid  = 1'b0;
    bus_if.resp_tready = 1'b0;
    bus_if.dtx_tdata   = '0;
    bus_if.dtx_tvalid  = 1'b0;
    bus_if.drx_tready  = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_range_error();
    test_ident_reset();
    test_mid_reset();
    test_random();
`ifdef USB_XFER_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
